// File: rtl/glob_regs_ckpt.sv
// Global param/descriptor register file with a checkpoint stack for microcode rollback.
// Optional macro GLOB_REGS_DESC_PIPE_EN registers the decoded base/limit outputs.
module glob_regs_ckpt #(
    parameter int PARAM_CNT  = 5,
    parameter int DESC_CNT   = 2,
    parameter int CKPT_DEPTH = 2,
    localparam int LVL_W     = $clog2(CKPT_DEPTH + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [PARAM_CNT-1:0]    param_set_i,
    input  logic [32*PARAM_CNT-1:0] param_value_i,
    input  logic [DESC_CNT-1:0]     desc_set_i,
    input  logic [64*DESC_CNT-1:0]  desc_value_i,
    input  logic                    ckpt_push_i,
    input  logic                    ckpt_pop_i,
    input  logic                    ckpt_flush_i,
    output logic [32*PARAM_CNT-1:0] param_o,
    output logic [64*DESC_CNT-1:0]  desc_o,
    output logic [32*DESC_CNT-1:0]  desc_base_o,
    output logic [32*DESC_CNT-1:0]  desc_limit_o,
    output logic [LVL_W-1:0]        ckpt_level_o,
    output logic                    ckpt_full_o,
    output logic                    ckpt_empty_o,
    output logic                    ckpt_err_o
);

    typedef logic [PARAM_CNT-1:0][31:0] param_t;
    typedef logic [DESC_CNT-1:0][63:0]  desc_t;
    typedef logic [DESC_CNT-1:0][31:0]  word_t;

    param_t              param_q, param_d;
    desc_t               desc_q, desc_d;
    param_t              stk_param_q [CKPT_DEPTH];
    desc_t               stk_desc_q  [CKPT_DEPTH];
    logic [LVL_W-1:0]    level_q, level_d;
    logic                err_q, err_d;

    logic                cmd_pop, cmd_push, restore, push_ok;
    param_t              top_param;
    desc_t               top_desc;
    word_t               base_c, limit_c;

    function automatic logic [31:0] base_of(input logic [63:0] d);
        return {d[63:56], d[39:16]};
    endfunction

    // Granularity bit scales the 20-bit limit to 4 KiB pages.
    function automatic logic [31:0] limit_of(input logic [63:0] d);
        return d[55] ? {d[51:48], d[15:0], 12'hFFF} : {12'd0, d[51:48], d[15:0]};
    endfunction

    // Flush wins outright; push and pop together cancel each other.
    always_comb begin
        cmd_pop  = ckpt_pop_i  & ~ckpt_push_i & ~ckpt_flush_i;
        cmd_push = ckpt_push_i & ~ckpt_pop_i  & ~ckpt_flush_i;
        restore  = cmd_pop  && (level_q != '0);
        push_ok  = cmd_push && (level_q != LVL_W'(CKPT_DEPTH));
    end

    always_comb begin
        top_param = '0;
        top_desc  = '0;
        for (int e = 0; e < CKPT_DEPTH; e++) begin
            if (level_q == LVL_W'(e + 1)) begin
                top_param = stk_param_q[e];
                top_desc  = stk_desc_q[e];
            end
        end
    end

    always_comb begin
        param_d = param_q;
        desc_d  = desc_q;
        if (restore) begin
            param_d = top_param;
            desc_d  = top_desc;
        end else begin
            for (int i = 0; i < PARAM_CNT; i++) begin
                if (param_set_i[i]) param_d[i] = param_value_i[32*i +: 32];
            end
            for (int j = 0; j < DESC_CNT; j++) begin
                if (desc_set_i[j]) desc_d[j] = desc_value_i[64*j +: 64];
            end
        end

        level_d = level_q;
        if (ckpt_flush_i)  level_d = '0;
        else if (restore)  level_d = level_q - LVL_W'(1);
        else if (push_ok)  level_d = level_q + LVL_W'(1);

        err_d = (cmd_pop && (level_q == '0)) || (cmd_push && !push_ok);
    end

    // Snapshot captures pre-write registers, so a write in the push cycle is not saved.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            param_q <= '0;
            desc_q  <= '0;
            level_q <= '0;
            err_q   <= 1'b0;
            for (int e = 0; e < CKPT_DEPTH; e++) begin
                stk_param_q[e] <= '0;
                stk_desc_q[e]  <= '0;
            end
        end else begin
            param_q <= param_d;
            desc_q  <= desc_d;
            level_q <= level_d;
            err_q   <= err_d;
            for (int e = 0; e < CKPT_DEPTH; e++) begin
                if (push_ok && (level_q == LVL_W'(e))) begin
                    stk_param_q[e] <= param_q;
                    stk_desc_q[e]  <= desc_q;
                end
            end
        end
    end

    always_comb begin
        base_c  = '0;
        limit_c = '0;
        for (int j = 0; j < DESC_CNT; j++) begin
            base_c[j]  = base_of(desc_q[j]);
            limit_c[j] = limit_of(desc_q[j]);
        end
    end

`ifdef GLOB_REGS_DESC_PIPE_EN
    word_t base_q, limit_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            base_q  <= '0;
            limit_q <= '0;
        end else begin
            base_q  <= base_c;
            limit_q <= limit_c;
        end
    end

    assign desc_base_o  = base_q;
    assign desc_limit_o = limit_q;
`else
    assign desc_base_o  = base_c;
    assign desc_limit_o = limit_c;
`endif

    assign param_o      = param_q;
    assign desc_o       = desc_q;
    assign ckpt_level_o = level_q;
    assign ckpt_full_o  = (level_q == LVL_W'(CKPT_DEPTH));
    assign ckpt_empty_o = (level_q == '0);
    assign ckpt_err_o   = err_q;

endmodule

// File: tb/tb_glob_regs_ckpt.sv
// Scoreboard bench for glob_regs_ckpt: a queue/array reference model predicts every
// cycle's outputs; a negedge monitor compares them, plus directed spot checks.
module tb_glob_regs_ckpt;

    localparam int P     = 5;
    localparam int D     = 2;
    localparam int DEPTH = 2;
    localparam int LW    = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [P-1:0]      param_set = '0;
    logic [32*P-1:0]   param_value = '0;
    logic [D-1:0]      desc_set = '0;
    logic [64*D-1:0]   desc_value = '0;
    logic              ckpt_push = 1'b0, ckpt_pop = 1'b0, ckpt_flush = 1'b0;
    logic [32*P-1:0]   param_o;
    logic [64*D-1:0]   desc_o;
    logic [32*D-1:0]   base_o, limit_o;
    logic [LW-1:0]     level_o;
    logic              full_o, empty_o, err_o;

    glob_regs_ckpt #(.PARAM_CNT(P), .DESC_CNT(D), .CKPT_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .param_set_i(param_set), .param_value_i(param_value),
        .desc_set_i(desc_set), .desc_value_i(desc_value),
        .ckpt_push_i(ckpt_push), .ckpt_pop_i(ckpt_pop), .ckpt_flush_i(ckpt_flush),
        .param_o(param_o), .desc_o(desc_o),
        .desc_base_o(base_o), .desc_limit_o(limit_o),
        .ckpt_level_o(level_o), .ckpt_full_o(full_o), .ckpt_empty_o(empty_o),
        .ckpt_err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              cyc;
        logic [32*P-1:0] param;
        logic [64*D-1:0] desc;
        logic [32*D-1:0] base;
        logic [32*D-1:0] limit;
        int              level;
        logic            err;
    } exp_t;

    typedef struct {
        logic [32*P-1:0] p;
        logic [64*D-1:0] d;
    } snap_t;

    exp_t            sb[$];
    exp_t            monE;
    snap_t           mStack[$];
    logic [32*P-1:0] mParam;
    logic [64*D-1:0] mDesc;
    logic [32*D-1:0] mBase, mLimit;
    logic            mErr;

    int cycle = 0;
    int nChecks = 0;
    int nFails = 0;

    logic [32*P-1:0] pv;
    logic [64*D-1:0] dv;
    logic [32*P-1:0] mask;

    always @(posedge clk) cycle <= cycle + 1;

    // Descriptor decode written from the field definitions, not the RTL concatenations.
    function automatic logic [32*D-1:0] decode(input logic [64*D-1:0] d, input bit wantLimit);
        logic [32*D-1:0] r;
        logic [63:0]     w;
        logic [31:0]     raw;
        r = '0;
        for (int j = 0; j < D; j++) begin
            w = d[64*j +: 64];
            if (!wantLimit) begin
                r[32*j +: 32] = (32'(w[63:56]) << 24) | 32'(w[39:16]);
            end else begin
                raw = (32'(w[51:48]) << 16) | 32'(w[15:0]);
                r[32*j +: 32] = w[55] ? ((raw << 12) | 32'hFFF) : raw;
            end
        end
        return r;
    endfunction

    task automatic checkVal(input string name, input logic [255:0] act, input logic [255:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s @cycle %0d: got %h expected %h", name, cycle, act, exp);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkVal("param", 256'(param_o), 256'(e.param));
        checkVal("desc", 256'(desc_o), 256'(e.desc));
        checkVal("desc_base", 256'(base_o), 256'(e.base));
        checkVal("desc_limit", 256'(limit_o), 256'(e.limit));
        checkVal("ckpt_level", 256'(level_o), 256'(e.level));
        checkVal("ckpt_full", 256'(full_o), 256'(e.level == DEPTH));
        checkVal("ckpt_empty", 256'(empty_o), 256'(e.level == 0));
        checkVal("ckpt_err", 256'(err_o), 256'(e.err));
    endtask

    function automatic exp_t snapshotModel(input int cyc);
        exp_t e;
        e.cyc   = cyc;
        e.param = mParam;
        e.desc  = mDesc;
        e.base  = mBase;
        e.limit = mLimit;
        e.level = mStack.size();
        e.err   = mErr;
        return e;
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cycle) begin
            monE = sb.pop_front();
            checkOutput(monE);
        end
    end

    // Called at posedge+1; drives one cycle of inputs and predicts the state after the next edge.
    task automatic applyStimulus(input logic [P-1:0] ps, input logic [32*P-1:0] pvIn,
                                 input logic [D-1:0] ds, input logic [64*D-1:0] dvIn,
                                 input logic push, input logic pop, input logic flush);
        logic [64*D-1:0] prevDesc;
        snap_t           s;
        bit              doSets;
        param_set = ps; param_value = pvIn; desc_set = ds; desc_value = dvIn;
        ckpt_push = push; ckpt_pop = pop; ckpt_flush = flush;

        prevDesc = mDesc;
        mErr     = 1'b0;
        doSets   = 1'b1;
        if (flush) begin
            mStack.delete();
        end else if (push && pop) begin
            doSets = 1'b1;
        end else if (pop) begin
            if (mStack.size() > 0) begin
                s = mStack.pop_back();
                mParam = s.p;
                mDesc  = s.d;
                doSets = 1'b0;
            end else begin
                mErr = 1'b1;
            end
        end else if (push) begin
            if (mStack.size() < DEPTH) mStack.push_back('{p: mParam, d: mDesc});
            else mErr = 1'b1;
        end
        if (doSets) begin
            for (int i = 0; i < P; i++) if (ps[i]) mParam[32*i +: 32] = pvIn[32*i +: 32];
            for (int j = 0; j < D; j++) if (ds[j]) mDesc[64*j +: 64] = dvIn[64*j +: 64];
        end
`ifdef GLOB_REGS_DESC_PIPE_EN
        mBase  = decode(prevDesc, 1'b0);
        mLimit = decode(prevDesc, 1'b1);
`else
        mBase  = decode(mDesc, 1'b0);
        mLimit = decode(mDesc, 1'b1);
`endif
        sb.push_back(snapshotModel(cycle + 1));
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus('0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // Asserts reset between edges, holds it across one edge, releases at posedge+1.
    task automatic resetDut();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        param_set = '0; param_value = '0; desc_set = '0; desc_value = '0;
        ckpt_push = 1'b0; ckpt_pop = 1'b0; ckpt_flush = 1'b0;
        mParam = '0; mDesc = '0; mBase = '0; mLimit = '0; mErr = 1'b0;
        mStack.delete();
        sb.push_back(snapshotModel(cycle + 1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetDut();
        checkVal("reset_param", 256'(param_o), 256'(0));
        checkVal("reset_desc", 256'(desc_o), 256'(0));
        checkVal("reset_level", 256'(level_o), 256'(0));
        checkVal("reset_empty", 256'(empty_o), 256'(1));

        pv = '0; pv[95:64] = 32'hDEADBEEF;
        applyStimulus(5'b00100, pv, '0, '0, 1'b0, 1'b0, 1'b0);
        mask = '0; mask[95:64] = '1;
        checkVal("param2_write", 256'(param_o[95:64]), 256'(32'hDEADBEEF));
        checkVal("other_params_zero", 256'(param_o & ~mask), 256'(0));

        dv = '0; dv[63:0] = 64'h00CF_9A00_0000_FFFF;
        applyStimulus('0, '0, 2'b01, dv, 1'b0, 1'b0, 1'b0);
        idle();
        checkVal("base_flat", 256'(base_o[31:0]), 256'(32'h0));
        checkVal("limit_gran", 256'(limit_o[31:0]), 256'(32'hFFFF_FFFF));

        dv = '0; dv[63:0] = 64'h1240_9A34_5678_FFFF;
        applyStimulus('0, '0, 2'b01, dv, 1'b0, 1'b0, 1'b0);
        idle();
        checkVal("base_mixed", 256'(base_o[31:0]), 256'(32'h1234_5678));
        checkVal("limit_byte", 256'(limit_o[31:0]), 256'(32'h0000_FFFF));

        pv = '0; pv[31:0] = 32'd1;
        applyStimulus(5'b00001, pv, '0, '0, 1'b0, 1'b0, 1'b0);
        pv[31:0] = 32'd2;
        applyStimulus(5'b00001, pv, '0, '0, 1'b1, 1'b0, 1'b0);
        checkVal("push_write_param0", 256'(param_o[31:0]), 256'(2));
        checkVal("push_level", 256'(level_o), 256'(1));
        applyStimulus('0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
        checkVal("pop_restore_param0", 256'(param_o[31:0]), 256'(1));
        checkVal("pop_level", 256'(level_o), 256'(0));

        applyStimulus('0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        applyStimulus('0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        applyStimulus('0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        checkVal("overflow_err", 256'(err_o), 256'(1));
        checkVal("overflow_level", 256'(level_o), 256'(DEPTH));
        checkVal("overflow_full", 256'(full_o), 256'(1));
        idle();
        checkVal("err_one_cycle", 256'(err_o), 256'(0));
        applyStimulus('0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
        applyStimulus('0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
        applyStimulus('0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
        checkVal("underflow_err", 256'(err_o), 256'(1));
        checkVal("underflow_level", 256'(level_o), 256'(0));

        applyStimulus('0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        applyStimulus('0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        pv = '0; pv[63:32] = 32'h0000_00AB;
        applyStimulus(5'b00010, pv, '0, '0, 1'b0, 1'b0, 1'b1);
        checkVal("flush_level", 256'(level_o), 256'(0));
        checkVal("flush_write", 256'(param_o[63:32]), 256'(32'hAB));
        applyStimulus('0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
        checkVal("pop_after_flush_err", 256'(err_o), 256'(1));

        applyStimulus('0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        pv = '0; pv[127:96] = 32'h55;
        applyStimulus(5'b01000, pv, '0, '0, 1'b1, 1'b1, 1'b0);
        checkVal("pushpop_level", 256'(level_o), 256'(1));
        checkVal("pushpop_err", 256'(err_o), 256'(0));
        checkVal("pushpop_write", 256'(param_o[127:96]), 256'(32'h55));
        resetDut();
        checkVal("midreset_param", 256'(param_o), 256'(0));
        checkVal("midreset_desc", 256'(desc_o), 256'(0));
        checkVal("midreset_base", 256'(base_o), 256'(0));
        checkVal("midreset_limit", 256'(limit_o), 256'(0));
        checkVal("midreset_level", 256'(level_o), 256'(0));

        for (int n = 0; n < 400; n++) begin
            logic [P-1:0] ps;
            logic [D-1:0] ds;
            for (int i = 0; i < P; i++) pv[32*i +: 32] = $urandom();
            for (int j = 0; j < D; j++) dv[64*j +: 64] = {$urandom(), $urandom()};
            ps = P'($urandom() & $urandom());
            ds = D'($urandom() & $urandom());
            if (n % 150 == 149) resetDut();
            else applyStimulus(ps, pv, ds, dv, ($urandom_range(0, 2) == 0),
                               ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
        end
        idle();
        idle();

        repeat (3) @(posedge clk);
        nChecks++;
        if (sb.size() != 0) begin
            nFails++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
